// File: rtl/uart_param_core_if.sv
// Parallel-side bundle for uart_param_core: TX byte handshake plus RX word/strobe/flags.
// The user side takes the master modport and the UART core takes the slave modport.
interface uart_param_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, parity_err, frame_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, parity_err, frame_err
    );
endinterface

// File: rtl/uart_param_core.sv
// Parameterised UART with independent TX and RX engines (start, data LSB first, optional parity, 1-2 stops).
// Define UART_PARAM_RX_SYNC_EN to pass RX through a two-flop synchronizer, which adds 2 cycles of RX latency.
module uart_param_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               reset,
    uart_param_core_if.slave   bus,
    output logic               TX,
    input  logic               RX
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam bit            HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // Parity bit that makes the ones-count odd (PARITY=1) or even (PARITY=2).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? (^d) : ~(^d);
    endfunction

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == 0) return 1'b0;
        return p != parity_bit(d);
    endfunction

    tx_state_t              tx_state;
    logic [CW-1:0]          tx_clk_cnt;
    logic [BW-1:0]          tx_bit_cnt;
    logic                   tx_stop_cnt;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_line;
    logic                   tx_rdy;
    logic                   tx_bit_end;

    rx_state_t              rx_state;
    logic [CW-1:0]          rx_clk_cnt;
    logic [BW-1:0]          rx_bit_cnt;
    logic                   rx_stop_cnt;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par;
    logic                   rx_ferr_acc;
    logic                   rx_in;
    logic                   rx_bit_end;
    logic                   rx_vld;
    logic [DATA_BITS-1:0]   rx_word;
    logic                   rx_perr;
    logic                   rx_ferr;

`ifdef UART_PARAM_RX_SYNC_EN
    logic rx_sync_p0;
    logic rx_sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= RX;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_in = rx_sync_p1;
`else
    assign rx_in = RX;
`endif

    assign tx_bit_end     = (tx_clk_cnt == CLK_LAST);
    assign rx_bit_end     = (rx_clk_cnt == CLK_LAST);
    assign TX             = tx_line;
    assign bus.tx_ready   = tx_rdy;
    assign bus.rx_valid   = rx_vld;
    assign bus.rx_data    = rx_word;
    assign bus.parity_err = rx_perr;
    assign bus.frame_err  = rx_ferr;

    // Transmitter: tx_data is latched at the handshake so later changes never reach the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_line     <= 1'b1;
            tx_rdy      <= 1'b1;
            tx_clk_cnt  <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
        end else begin
            if (tx_state != TX_IDLE)
                tx_clk_cnt <= tx_bit_end ? '0 : tx_clk_cnt + CW'(1);
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_valid && tx_rdy) begin
                        tx_shift   <= bus.tx_data;
                        tx_par     <= parity_bit(bus.tx_data);
                        tx_rdy     <= 1'b0;
                        tx_line    <= 1'b0;
                        tx_clk_cnt <= '0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_line    <= tx_shift[0];
                        tx_bit_cnt <= '0;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == BIT_LAST) begin
                            tx_stop_cnt <= 1'b0;
                            if (HAS_PAR) begin
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_shift   <= tx_shift >> 1;
                            tx_line    <= tx_shift[1];
                            tx_bit_cnt <= tx_bit_cnt + BW'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop_cnt == STOP_LAST) begin
                            tx_rdy   <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Receiver: mid-bit sampling anchored on the start-bit re-check at CLK_HALF.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            rx_clk_cnt  <= '0;
            rx_bit_cnt  <= '0;
            rx_stop_cnt <= 1'b0;
            rx_ferr_acc <= 1'b0;
            rx_vld      <= 1'b0;
            rx_word     <= '0;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_in) begin
                        rx_clk_cnt <= '0;
                        rx_state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_clk_cnt == CLK_HALF) begin
                        rx_clk_cnt <= '0;
                        rx_bit_cnt <= '0;
                        rx_state   <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_clk_cnt <= '0;
                        rx_shift   <= {rx_in, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == BIT_LAST) begin
                            rx_stop_cnt <= 1'b0;
                            rx_ferr_acc <= 1'b0;
                            rx_state    <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + BW'(1);
                        end
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_clk_cnt <= '0;
                        rx_par     <= rx_in;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_clk_cnt <= '0;
                        if (rx_stop_cnt == STOP_LAST) begin
                            rx_vld   <= 1'b1;
                            rx_word  <= rx_shift;
                            rx_perr  <= parity_error(rx_shift, rx_par);
                            rx_ferr  <= rx_ferr_acc | ~rx_in;
                            rx_state <= (rx_ferr_acc | ~rx_in) ? RX_BREAK : RX_IDLE;
                        end else begin
                            rx_stop_cnt <= 1'b1;
                            rx_ferr_acc <= rx_ferr_acc | ~rx_in;
                        end
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rx_in) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule
